// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with round-robin or fixed-select arbitration
// feeding a single registered output stage.
module stream_mux_rr #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SW    = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SW-1:0]        sel,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SW-1:0]        out_ch
);

   localparam int SW1 = SW + 1;

   logic             out_valid_reg, out_valid_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic [SW-1:0]    out_ch_reg, out_ch_next;
   logic [SW-1:0]    ptr_reg, ptr_next;

   logic             load_en;
   logic             rr_found, fx_found, grant_valid;
   logic [SW-1:0]    rr_idx, grant_idx;
   logic [SW-1:0]    cand_idx [NCH];
   logic [NCH-1:0]   cand_valid;
   logic [WIDTH-1:0] ch_data [NCH];

   assign load_en = ~out_valid_reg | out_ready;

   // Candidate gi is the channel gi places above ptr, wrapped modulo NCH.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
      logic [SW:0] sum;
      assign sum            = {1'b0, ptr_reg} + SW1'(gi);
      assign cand_idx[gi]   = (sum >= SW1'(NCH)) ? SW'(sum - SW1'(NCH)) : SW'(sum);
      assign cand_valid[gi] = in_valid[cand_idx[gi]];
      assign ch_data[gi]    = in_data[gi*WIDTH +: WIDTH];
   end

   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!rr_found && cand_valid[k]) begin
            rr_found = 1'b1;
            rr_idx   = cand_idx[k];
         end
      end
   end

   // An out-of-range sel never matches any channel, so it yields no grant.
   always_comb begin
      fx_found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == SW'(k)) fx_found = in_valid[k];
      end
   end

   assign grant_valid = mode ? fx_found : rr_found;
   assign grant_idx   = mode ? sel : rr_idx;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = ~rst & load_en & grant_valid & (grant_idx == SW'(gi));
   end

   always_comb begin
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_ch_next    = out_ch_reg;
      ptr_next       = ptr_reg;
      if (load_en) begin
         out_valid_next = grant_valid;
         if (grant_valid) begin
            out_data_next = ch_data[grant_idx];
            out_ch_next   = grant_idx;
            if (!mode) begin
               ptr_next = (grant_idx == SW'(NCH - 1)) ? '0 : grant_idx + SW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         ptr_reg       <= '0;
      end else begin
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_ch_reg    <= out_ch_next;
         ptr_reg       <= ptr_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (NCH=8, WIDTH=8) with a
// hand-written backpressure/data-independence sequence.
module tb_stream_mux_rr;

   localparam int WIDTH = 8;
   localparam int NCH   = 8;
   localparam int SW    = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 mode = 1'b0;
   logic [SW-1:0]        sel = '0;
   logic [NCH-1:0]       in_valid = '0;
   logic [NCH*WIDTH-1:0] in_data = '0;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [WIDTH-1:0]     out_data;
   logic [SW-1:0]        out_ch;

   int tests_run = 0;
   int tests_failed = 0;

   stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       mode;
      logic [2:0] sel;
      logic [7:0] iv;
      logic       ordy;
      logic [7:0] e_rdy;
      logic       e_ov;
      logic [7:0] e_data;
      logic [2:0] e_ch;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic m, logic [2:0] s, logic [7:0] iv,
                               logic ordy, logic [7:0] e_rdy, logic e_ov,
                               logic [7:0] e_data, logic [2:0] e_ch);
      vec_t v;
      v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data; v.e_ch = e_ch;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_data(input logic [7:0] base);
      for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = base + 8'(i);
   endtask

   initial begin
      set_data(8'h10);

      // reset
      vecs.push_back(mk(1, 0, 0, 8'hFF, 1, 8'h00, 0, 8'h00, 0));
      // round-robin sweep 0..7 then wrap to 0, no bubbles
      for (int i = 0; i < NCH; i++)
         vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'(1 << i), 1, 8'h10 + 8'(i), 3'(i)));
      vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h01, 1, 8'h10, 0));
      // backpressure three cycles, then drain and load on the same edge
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h00, 1, 8'h10, 0));
      vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h02, 1, 8'h11, 1));
      // fixed mode sel=3, then channel 3 idle
      vecs.push_back(mk(0, 1, 3, 8'hFF, 1, 8'h08, 1, 8'h13, 3));
      vecs.push_back(mk(0, 1, 3, 8'hFF, 1, 8'h08, 1, 8'h13, 3));
      vecs.push_back(mk(0, 1, 3, 8'hF7, 1, 8'h00, 0, 8'h13, 3));
      // back to round-robin: ptr kept at 2
      vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h04, 1, 8'h12, 2));
      // move ptr to 6, then fairness with wrap on 0000_0101
      vecs.push_back(mk(0, 0, 0, 8'h20, 1, 8'h20, 1, 8'h15, 5));
      vecs.push_back(mk(0, 0, 0, 8'h05, 1, 8'h01, 1, 8'h10, 0));
      vecs.push_back(mk(0, 0, 0, 8'h05, 1, 8'h04, 1, 8'h12, 2));
      vecs.push_back(mk(0, 0, 0, 8'h05, 1, 8'h01, 1, 8'h10, 0));
      // idle
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h10, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h10, 0));
      // reset mid-stream while a word is held
      vecs.push_back(mk(0, 0, 0, 8'h10, 1, 8'h10, 1, 8'h14, 4));
      vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h00, 1, 8'h14, 4));
      vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 0, 8'hFF, 0, 8'h01, 1, 8'h10, 0));
      // mode/sel change while held, then fixed grant keeps ptr=1
      vecs.push_back(mk(0, 1, 5, 8'hFF, 0, 8'h00, 1, 8'h10, 0));
      vecs.push_back(mk(0, 1, 5, 8'hFF, 1, 8'h20, 1, 8'h15, 5));
      vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h02, 1, 8'h11, 1));

      foreach (vecs[n]) begin
         @(negedge clk);
         rst = vecs[n].rst; mode = vecs[n].mode; sel = vecs[n].sel;
         in_valid = vecs[n].iv; out_ready = vecs[n].ordy;
         #1;
         check($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(vecs[n].e_rdy));
         @(posedge clk); #1;
         check($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(vecs[n].e_ov));
         check($sformatf("v%0d out_data", n), 32'(out_data), 32'(vecs[n].e_data));
         check($sformatf("v%0d out_ch", n), 32'(out_ch), 32'(vecs[n].e_ch));
         $display("[TB] vec %0d: in_ready=%02h out_valid=%0d out_data=%02h out_ch=%0d",
                  n, in_ready, out_valid, out_data, out_ch);
      end

      // held word must not follow changing in_data; the new data loads on release
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0; mode = 1'b0; in_valid = 8'hFF;
         set_data(8'hA0 + 8'(c * 16));
         #1;
         check($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'h0);
         @(posedge clk); #1;
         check($sformatf("hold%0d out_data", c), 32'(out_data), 32'h11);
         check($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'h1);
         $display("[TB] hold %0d: out_data=%02h out_valid=%0d", c, out_data, out_valid);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("release in_ready", 32'(in_ready), 32'h04);
      @(posedge clk); #1;
      check("release out_data", 32'(out_data), 32'hC2);
      check("release out_ch", 32'(out_ch), 32'h2);
      $display("[TB] release: out_data=%02h out_ch=%0d", out_data, out_ch);
      @(negedge clk);
      in_valid = 8'h00;
      @(posedge clk); #1;
      check("drain out_valid", 32'(out_valid), 32'h0);
      $display("[TB] drain: out_valid=%0d", out_valid);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal range >= 1).
REQ-002 The module SHALL have parameter NCH, default 8, meaning number of input channels (legal range >= 2).
REQ-003 The module SHALL have parameter SW, default $clog2(NCH), meaning select and channel-index width.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mode  input  1  0 = round-robin arbitration, 1 = fixed select.
REQ-007 sel  input  SW  channel chosen when mode=1.
REQ-008 in_valid  input  NCH  per-channel valid; bit i belongs to channel i.
REQ-009 in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  NCH  per-channel accept; combinational.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_data  output  WIDTH  registered selected word.
REQ-014 out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-015 The output stage SHALL be a single register; load_en = !out_valid | out_ready.
REQ-016 A channel transfer SHALL occur on a rising edge where in_valid[i] & in_ready[i] = 1; an output transfer SHALL occur on a rising edge where out_valid & out_ready = 1.
REQ-017 At most one in_ready bit SHALL be 1 in any cycle; in_ready[i] = load_en & grant[i].
REQ-018 In mode=0, grant SHALL go to the first channel with in_valid set, searching upward from ptr and wrapping from NCH-1 to 0.
REQ-019 In mode=1, grant SHALL go to channel sel only when in_valid[sel]=1; when sel >= NCH, no grant is issued.
REQ-020 Grant SHALL depend only on the current in_valid, mode, sel and ptr, and SHALL NOT depend on in_data.
REQ-021 On a channel transfer from channel g, the next edge SHALL load out_data <= in_data[g], set out_ch <= g and set out_valid <= 1; latency from input to output is 1 cycle.
REQ-022 When load_en=1 and no grant is issued, out_valid SHALL go to 0; out_data and out_ch SHALL hold their values.
REQ-023 When load_en=0 (out_valid=1, out_ready=0), out_valid, out_data and out_ch SHALL hold, and all in_ready bits SHALL be 0.
REQ-024 Simultaneous output drain and new load SHALL sustain one word per cycle with no bubble.
REQ-025 The internal pointer ptr (SW bits) SHALL update to (g+1) mod NCH on a mode=0 channel transfer, with g=NCH-1 wrapping to 0.
REQ-026 ptr SHALL hold on mode=1 transfers and on idle cycles, and SHALL be kept across changes of mode.
REQ-027 A mode or sel change SHALL take effect on the same cycle's grant and SHALL NOT disturb a word already held in the output register.
REQ-028 in_valid on a channel that is not granted SHALL be ignored; that channel's data is not consumed.

Reset
REQ-029 While rst=1 at a rising edge, the next state SHALL be out_valid=0, out_data=0, out_ch=0 and ptr=0.
REQ-030 While rst=1, in_ready SHALL be all 0.
REQ-031 Reset asserted mid-operation SHALL discard any held output word, without a final out_valid pulse.
REQ-032 The first cycle after rst deasserts SHALL arbitrate normally from ptr=0.

Verification
REQ-033 The bench SHALL use NCH=8 and WIDTH=8, and SHALL cover the following scenarios.
REQ-034 Round-robin sweep: mode=0, in_valid=8'hFF, in_data[i]=8'h10+i, out_ready=1 -> out_ch 0,1,...,7,0 on consecutive cycles, out_data=8'h10+out_ch, out_valid continuously 1 from cycle 2.
REQ-035 Fairness with wrap: ptr=6, in_valid=8'b0000_0101 -> grant channel 0, then channel 2, then channel 0.
REQ-036 Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, out_data stable; out_ready=1 -> the next word loads on the same edge as the drain.
REQ-037 Fixed mode: mode=1, sel=3, in_valid=8'hFF -> only in_ready[3]=1, out_ch=3 each cycle, ptr unchanged; with in_valid[3]=0 -> out_valid falls to 0 after the drain.
REQ-038 Reset mid-stream: rst=1 for one edge while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_ch=0; the next grant starts from channel 0.
REQ-039 Idle: in_valid=0 and out_ready=1 -> out_valid falls to 0 one cycle after the last word and in_ready stays all 0.
